// File: rtl/mips_pkg.sv
// Shared MIPS core constants: datapath widths and memory access-size encodings.
package mips_pkg;

   localparam int unsigned LEN         = 32;
   localparam int unsigned NB_REG_ADDR = 5;

   localparam logic [1:0] MEM_BYTE = 2'b00;
   localparam logic [1:0] MEM_HALF = 2'b01;
   localparam logic [1:0] MEM_WORD = 2'b10;

endpackage

// File: rtl/data_memory.sv
// Byte-enabled data RAM: read-first synchronous read port plus async debug read.
module data_memory #(
   parameter int unsigned Width = 32,
   parameter int unsigned Depth = 128,
   localparam int unsigned Aw   = $clog2(Depth),
   localparam int unsigned Nb   = Width / 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             rd_en_i,
   input  logic [Aw-1:0]    addr_i,
   input  logic [Nb-1:0]    we_i,
   input  logic [Width-1:0] wdata_i,
   output logic [Width-1:0] rdata_o,
   input  logic [Aw-1:0]    debug_addr_i,
   output logic [Width-1:0] debug_data_o
);

   logic [Width-1:0] mem_q [Depth];
   logic [Width-1:0] rdata_q;

   // A store sampled while reset is low is dropped.
   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         for (int b = 0; b < Nb; b++) begin
            if (we_i[b]) begin
               mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q <= '0;
      end else if (rd_en_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o      = rdata_q;
   assign debug_data_o = mem_q[debug_addr_i];

endmodule

// File: rtl/tl_memory.sv
// MEM stage: byte/half/word load-store, MEM/WB register and debug read port.
// Define MEM_MISALIGN_CHECK_EN to flag and suppress misaligned accesses.
module tl_memory #(
   parameter int unsigned LEN         = mips_pkg::LEN,
   parameter int unsigned RAM_DEPTH   = 128,
   parameter int unsigned NB_REG_ADDR = mips_pkg::NB_REG_ADDR
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic [LEN-1:0]               i_alu_result,
   input  logic [LEN-1:0]               i_dato2,
   input  logic                         i_mem_read,
   input  logic                         i_mem_write,
   input  logic [1:0]                   i_mem_size,
   input  logic                         i_mem_unsigned,
   input  logic                         i_reg_write,
   input  logic                         i_mem_to_reg,
   input  logic [NB_REG_ADDR-1:0]       i_write_reg,
   input  logic                         i_stall,
   input  logic [$clog2(RAM_DEPTH)-1:0] i_debug_addr,
   output logic [LEN-1:0]               o_read_data,
   output logic [LEN-1:0]               o_alu_result,
   output logic [NB_REG_ADDR-1:0]       o_write_reg,
   output logic                         o_reg_write,
   output logic                         o_mem_to_reg,
`ifdef MEM_MISALIGN_CHECK_EN
   output logic [LEN-1:0]               o_debug_data,
   output logic                         o_misaligned
`else
   output logic [LEN-1:0]               o_debug_data
`endif
);
   import mips_pkg::*;

   localparam int unsigned AW = $clog2(RAM_DEPTH);
   localparam int unsigned NB = LEN / 8;

   logic [1:0]             addr_lo, size_d, off_d, size_q, off_q;
   logic                   misaligned_d, read_d, read_q, uns_q;
   logic [NB-1:0]          be_base, we;
   logic [LEN-1:0]         wdata, rdata, lane, ext;
   logic [LEN-1:0]         alu_q;
   logic [NB_REG_ADDR-1:0] write_reg_q;
   logic                   reg_write_q, mem_to_reg_q;

   assign addr_lo = i_alu_result[1:0];

   // Without the check, low address bits a size cannot use are simply ignored.
   always_comb begin
      size_d = (i_mem_size == MEM_BYTE || i_mem_size == MEM_HALF) ? i_mem_size : MEM_WORD;
      case (size_d)
         MEM_BYTE: begin
            off_d   = addr_lo;
            be_base = NB'(1);
            wdata   = {NB{i_dato2[7:0]}};
         end
         MEM_HALF: begin
            off_d   = {addr_lo[1], 1'b0};
            be_base = NB'(3);
            wdata   = {(NB/2){i_dato2[15:0]}};
         end
         default: begin
            off_d   = 2'b00;
            be_base = '1;
            wdata   = i_dato2;
         end
      endcase
`ifdef MEM_MISALIGN_CHECK_EN
      misaligned_d = (size_d == MEM_HALF && addr_lo[0]) ||
                     (size_d == MEM_WORD && addr_lo != 2'b00);
`else
      misaligned_d = 1'b0;
`endif
      read_d = i_mem_read && !misaligned_d;
      we     = (i_mem_write && !i_stall && !misaligned_d) ? be_base << off_d : '0;
   end

   data_memory #(
      .Width (LEN),
      .Depth (RAM_DEPTH)
   ) u_data_memory (
      .clk_i        (i_clk),
      .rst_ni       (i_rst),
      .rd_en_i      (!i_stall),
      .addr_i       (i_alu_result[AW+1:2]),
      .we_i         (we),
      .wdata_i      (wdata),
      .rdata_o      (rdata),
      .debug_addr_i (i_debug_addr),
      .debug_data_o (o_debug_data)
   );

   // MEM/WB register; the raw word is registered inside data_memory.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         size_q       <= MEM_BYTE;
         off_q        <= 2'b00;
         uns_q        <= 1'b0;
         read_q       <= 1'b0;
         alu_q        <= '0;
         write_reg_q  <= '0;
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
      end else if (!i_stall) begin
         size_q       <= size_d;
         off_q        <= off_d;
         uns_q        <= i_mem_unsigned;
         read_q       <= read_d;
         alu_q        <= i_alu_result;
         write_reg_q  <= i_write_reg;
         reg_write_q  <= i_reg_write;
         mem_to_reg_q <= i_mem_to_reg;
      end
   end

`ifdef MEM_MISALIGN_CHECK_EN
   logic misaligned_q;
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         misaligned_q <= 1'b0;
      end else if (!i_stall) begin
         misaligned_q <= misaligned_d;
      end
   end
   assign o_misaligned = misaligned_q;
`endif

   always_comb begin
      lane = rdata >> {off_q, 3'b000};
      case (size_q)
         MEM_BYTE: ext = {{(LEN-8){!uns_q && lane[7]}}, lane[7:0]};
         MEM_HALF: ext = {{(LEN-16){!uns_q && lane[15]}}, lane[15:0]};
         default:  ext = lane;
      endcase
   end

   assign o_read_data  = read_q ? ext : '0;
   assign o_alu_result = alu_q;
   assign o_write_reg  = write_reg_q;
   assign o_reg_write  = reg_write_q;
   assign o_mem_to_reg = mem_to_reg_q;

endmodule
